// File: rtl/beta_if_stage_pkg.sv
// Shared types and constants for the beta IF stage: fetch-unit FSM states and the NOP encoding.
package beta_if_stage_pkg;

    localparam int fu_fsm_bsize = 2;

    typedef enum logic [fu_fsm_bsize-1:0] {
        FU_IDLE  = 2'd0,
        FU_FETCH = 2'd1,
        FU_FLUSH = 2'd2
    } fu_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/beta_fetch_fifo.sv
// Synchronous FIFO with flush; used both as the prefetch queue and as the in-flight pc-tag FIFO.
module beta_fetch_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [Width-1:0]           i_wdata,
    output logic [Width-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_rdPtr;
    logic [PtrW-1:0]  r_wrPtr;
    logic [CntW-1:0]  r_count;
    logic             w_pushEn;
    logic             w_popEn;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CntW'(Depth));
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];
    // A pop frees a slot in the same cycle, so push at full is accepted alongside it
    assign w_popEn  = i_pop & ~o_empty;
    assign w_pushEn = i_push & (~o_full | w_popEn);

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushEn) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_popEn)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_pushEn, w_popEn})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pushEn) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/beta_prefetch_fetch_unit.sv
// Pipelined IF fetch unit: issues up to MaxOutstanding memory requests, buffers words in a
// prefetch queue, and on a ctrl/trap hazard flushes, drops stale responses and redirects.
module beta_prefetch_fetch_unit
    import beta_if_stage_pkg::*;
#(
    parameter int unsigned          DataWidth      = 32,
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          FifoDepth      = 4,
    parameter int unsigned          MaxOutstanding = 2,
    parameter logic [AddrWidth-1:0] BootAddr       = '0,
    parameter logic [DataWidth-1:0] NopInstr       = DataWidth'(NOP_INSTR)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 if_fu_fetch_en_i,
    output logic                 if_fu_instr_req_o,
    output logic [AddrWidth-1:0] if_fu_instr_addr_o,
    input  logic                 if_fu_instr_ready_i,
    input  logic                 if_fu_instr_valid_i,
    input  logic [DataWidth-1:0] if_fu_instr_rdata_i,
    output logic [DataWidth-1:0] if_fu_instr_o,
    output logic [AddrWidth-1:0] if_fu_pc_o,
    output logic                 if_fu_new_instr_o,
    input  logic                 if_fu_instr_consume_i,
    input  logic [AddrWidth-1:0] if_fu_redirect_addr_i,
    input  logic                 if_fu_ctrl_hazard_flag_i,
    input  logic                 if_fu_trap_hazard_flag_i,
    output logic [1:0]           if_fu_penality_o,
    output logic                 if_fu_stage_busy_o
);

    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned SumW = CntW + 1;
    localparam int unsigned QW   = DataWidth + AddrWidth;

    fu_state_t            r_state;
    fu_state_t            w_stateNext;
    logic [AddrWidth-1:0] r_fetchPc;
    logic [OutW-1:0]      r_outstanding;
    logic [OutW-1:0]      r_discard;
    logic [OutW-1:0]      w_outstandingNext;
    logic [SumW-1:0]      w_inFlight;
    logic                 w_hazard;
    logic                 w_grant;
    logic                 w_resp;
    logic                 w_drop;
    logic                 w_accept;
    logic                 w_pop;
    logic [QW-1:0]        w_qHead;
    logic                 w_qEmpty;
    logic                 w_qFull;
    logic [CntW-1:0]      w_qCount;
    logic [AddrWidth-1:0] w_tagHead;
    logic                 w_tagEmpty;
    logic                 w_tagFull;
    logic [OutW-1:0]      w_tagCount;
    logic                 w_unused;

    assign w_hazard   = if_fu_ctrl_hazard_flag_i | if_fu_trap_hazard_flag_i;
    assign w_grant    = if_fu_instr_req_o & if_fu_instr_ready_i;
    assign w_resp     = if_fu_instr_valid_i & (r_outstanding != '0);
    assign w_drop     = w_resp & (r_discard != '0);
    assign w_accept   = w_resp & ~w_drop & ~w_tagEmpty;
    assign w_pop      = if_fu_instr_consume_i & if_fu_new_instr_o;
    assign w_outstandingNext = r_outstanding + OutW'(w_grant) - OutW'(w_resp);
    // Queued words plus in-flight requests never exceed the queue, so every grant has a slot
    assign w_inFlight = {1'b0, w_qCount} + SumW'(r_outstanding);
    assign w_unused   = ^{w_qFull, w_tagFull, w_tagCount};

    assign if_fu_instr_req_o  = (r_state == FU_FETCH) & if_fu_fetch_en_i
                              & (r_outstanding < OutW'(MaxOutstanding))
                              & (w_inFlight < SumW'(FifoDepth));
    assign if_fu_instr_addr_o = r_fetchPc;
    assign if_fu_new_instr_o  = ~w_qEmpty & ~w_hazard;
    assign if_fu_instr_o      = if_fu_new_instr_o ? w_qHead[AddrWidth +: DataWidth] : NopInstr;
    assign if_fu_pc_o         = w_qEmpty ? r_fetchPc : w_qHead[AddrWidth-1:0];
    assign if_fu_penality_o   = {if_fu_trap_hazard_flag_i, if_fu_ctrl_hazard_flag_i};
    assign if_fu_stage_busy_o = (r_outstanding != '0) | (r_discard != '0);

    always_comb begin
        w_stateNext = r_state;
        if (w_hazard) begin
            w_stateNext = FU_FLUSH;
        end else begin
            case (r_state)
                FU_IDLE:  if (if_fu_fetch_en_i) w_stateNext = FU_FETCH;
                FU_FETCH: if (!if_fu_fetch_en_i) w_stateNext = FU_IDLE;
                FU_FLUSH: w_stateNext = if_fu_fetch_en_i ? FU_FETCH : FU_IDLE;
                default:  w_stateNext = FU_IDLE;
            endcase
        end
    end

    // Every request still in flight at a hazard, including one granted this cycle, is stale
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state       <= FU_IDLE;
            r_fetchPc     <= BootAddr;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_outstanding <= w_outstandingNext;
            if (w_hazard) begin
                r_fetchPc <= if_fu_redirect_addr_i;
                r_discard <= w_outstandingNext;
            end else begin
                if (w_grant) r_fetchPc <= r_fetchPc + AddrWidth'(4);
                if (w_drop)  r_discard <= r_discard - OutW'(1);
            end
        end
    end

    beta_fetch_fifo #(
        .Width (QW),
        .Depth (FifoDepth)
    ) u_instrQueue (
        .i_clk   (clk_i),
        .i_rstn  (rstn_i),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (w_hazard),
        .i_wdata ({if_fu_instr_rdata_i, w_tagHead}),
        .o_rdata (w_qHead),
        .o_full  (w_qFull),
        .o_empty (w_qEmpty),
        .o_count (w_qCount)
    );

    beta_fetch_fifo #(
        .Width (AddrWidth),
        .Depth (MaxOutstanding)
    ) u_tagFifo (
        .i_clk   (clk_i),
        .i_rstn  (rstn_i),
        .i_push  (w_grant),
        .i_pop   (w_accept),
        .i_flush (w_hazard),
        .i_wdata (r_fetchPc),
        .o_rdata (w_tagHead),
        .o_full  (w_tagFull),
        .o_empty (w_tagEmpty),
        .o_count (w_tagCount)
    );

endmodule
